// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipe: load-use bubbles, taken-branch squash,
// and a data-memory handshake that freezes the whole pipe, with debug counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned REG_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             mem_access_MEM,
   input  logic             dmem_ready,
   input  logic             branch_taken_EX,
   output logic             dmem_req,
   output logic             stall_PC,
   output logic             stall_IF_ID,
   output logic             stall_ID_EX,
   output logic             stall_EX_MEM,
   output logic             stall_MEM_WB,
   output logic             flush_IF_ID,
   output logic             flush_ID_EX,
   output logic             mem_timeout,
   output logic [15:0]      stall_cycles
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic        timeout_q, timeout_d;
   logic [15:0] scnt_q, scnt_d;

   logic mem_stall, req, lu, br;
   logic s_pc, s_ifid, s_idex, s_exmem, s_memwb, f_ifid, f_idex;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      mem_stall = 1'b0;
      req       = 1'b0;
      s_pc      = 1'b0;
      s_ifid    = 1'b0;
      s_idex    = 1'b0;
      s_exmem   = 1'b0;
      s_memwb   = 1'b0;
      f_ifid    = 1'b0;
      f_idex    = 1'b0;

      case (state_q)
         RUN: begin
            req = mem_access_MEM;
            if (mem_access_MEM && !dmem_ready) begin
               mem_stall = 1'b1;
               state_d   = MEM_WAIT;
               wait_d    = 8'd1;
            end
         end
         MEM_WAIT: begin
            req = 1'b1;
            if (!dmem_ready) begin
               mem_stall = 1'b1;
               wait_d    = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
            end else begin
               state_d = RUN;
               wait_d  = '0;
            end
         end
         default: state_d = RUN;
      endcase

      if (mem_stall && (wait_d >= 8'(MAX_WAIT)))
         timeout_d = 1'b1;

      lu = ex_mem_read && (ex_rd != '0) &&
           ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
      br = branch_taken_EX;

      // Memory freeze holds EX, so branch/load-use are re-judged on the release cycle.
      if (mem_stall) begin
         s_pc    = 1'b1;
         s_ifid  = 1'b1;
         s_idex  = 1'b1;
         s_exmem = 1'b1;
         s_memwb = 1'b1;
      end else if (br) begin
         f_ifid = 1'b1;
         f_idex = 1'b1;
      end else if (lu) begin
         s_pc   = 1'b1;
         s_ifid = 1'b1;
         f_idex = 1'b1;
      end

      scnt_d = (s_pc && (scnt_q != 16'hFFFF)) ? scnt_q + 16'd1 : scnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         scnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         scnt_q    <= scnt_d;
      end
   end

   // Combinational outputs are gated so reset drops them in the same cycle.
   assign dmem_req     = rst_n & req;
   assign stall_PC     = rst_n & s_pc;
   assign stall_IF_ID  = rst_n & s_ifid;
   assign stall_ID_EX  = rst_n & s_idex;
   assign stall_EX_MEM = rst_n & s_exmem;
   assign stall_MEM_WB = rst_n & s_memwb;
   assign flush_IF_ID  = rst_n & f_ifid;
   assign flush_ID_EX  = rst_n & f_idex;
   assign mem_timeout  = timeout_q;
   assign stall_cycles = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus randomized checks of pipe_hazard_ctrl against a behavioural model
// that tracks "waiting on memory", the length of the current wait, and total stalls.
module tb_pipe_hazard_ctrl;

   localparam int MW = 4;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic          mem_access_MEM = 1'b0, dmem_ready = 1'b0, branch_taken_EX = 1'b0;
   logic          dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
   logic          flush_IF_ID, flush_ID_EX, mem_timeout;
   logic [15:0]   stall_cycles;
   logic [7:0]    obs;

   int checks = 0;
   int errors = 0;

   bit m_wait, m_to;
   int m_run, m_sc;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MAX_WAIT(MW), .REG_W(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .mem_access_MEM(mem_access_MEM), .dmem_ready(dmem_ready),
      .branch_taken_EX(branch_taken_EX),
      .dmem_req(dmem_req), .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID),
      .stall_ID_EX(stall_ID_EX), .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
      .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   assign obs = {dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                 flush_IF_ID, flush_ID_EX};

   task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      m_wait = 1'b0;
      m_to   = 1'b0;
      m_run  = 0;
      m_sc   = 0;
   endtask

   task automatic idle();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      mem_access_MEM = 1'b0; dmem_ready = 1'b0; branch_taken_EX = 1'b0;
   endtask

   task automatic set_lu(input logic [RW-1:0] rd);
      ex_mem_read = 1'b1; ex_rd = rd; id_rs = 4'd3; id_uses_rs = 1'b1;
   endtask

   // One clock: check combinational outputs mid-cycle, then registered state after the edge.
   task automatic cyc();
      bit busy, lu, br, spc;
      logic [7:0] e;
      @(negedge clk);
      busy = m_wait ? !dmem_ready : (mem_access_MEM && !dmem_ready);
      lu = ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      br = branch_taken_EX;
      spc = busy || (!br && lu);
      e = {m_wait || mem_access_MEM, spc, spc, busy, busy, busy,
           !busy && br, !busy && (br || lu)};
      chk("outputs", {8'h00, obs}, {8'h00, e});
      @(posedge clk);
      #1;
      m_wait = busy;
      m_run  = busy ? m_run + 1 : 0;
      if (busy && m_run >= MW) m_to = 1'b1;
      if (spc) m_sc++;
      chk("mem_timeout", {15'h0, mem_timeout}, {15'h0, m_to});
      chk("stall_cycles", stall_cycles, (m_sc > 65535) ? 16'hFFFF : 16'(m_sc));
   endtask

   initial begin
      idle();
      model_reset();
      #12;
      chk("reset_outputs", {8'h00, obs}, 16'h0000);
      chk("reset_stall_cycles", stall_cycles, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cyc();
      set_lu(4'd3);
      cyc();
      idle();
      cyc();
      chk("lu_one_stall", stall_cycles, 16'd1);
      set_lu(4'd0);
      cyc();
      idle();
      chk("lu_r0_no_stall", stall_cycles, 16'd1);

      mem_access_MEM = 1'b1;
      repeat (3) cyc();
      dmem_ready = 1'b1;
      cyc();
      idle();
      cyc();
      chk("wait3_no_timeout", {15'h0, mem_timeout}, 16'h0000);
      chk("wait3_stalls", stall_cycles, 16'd4);

      mem_access_MEM = 1'b1;
      repeat (6) cyc();
      chk("timeout_set", {15'h0, mem_timeout}, 16'h0001);
      dmem_ready = 1'b1;
      cyc();
      idle();
      mem_access_MEM = 1'b1;
      dmem_ready = 1'b1;
      cyc();
      idle();
      cyc();
      chk("timeout_sticky", {15'h0, mem_timeout}, 16'h0001);

      set_lu(4'd3);
      branch_taken_EX = 1'b1;
      cyc();
      idle();

      branch_taken_EX = 1'b1;
      mem_access_MEM = 1'b1;
      repeat (2) cyc();
      dmem_ready = 1'b1;
      cyc();
      idle();
      cyc();

      for (int i = 0; i < 400; i++) begin
         id_rs = 4'($urandom_range(0, 3));
         id_rt = 4'($urandom_range(0, 3));
         ex_rd = 4'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom);
         id_uses_rt = 1'($urandom);
         ex_mem_read = 1'($urandom);
         mem_access_MEM = ($urandom_range(0, 3) == 0);
         dmem_ready = ($urandom_range(0, 2) != 0);
         branch_taken_EX = ($urandom_range(0, 4) == 0);
         cyc();
      end

      idle();
      mem_access_MEM = 1'b1;
      repeat (2) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {8'h00, obs}, 16'h0000);
      chk("rst_mid_stall_cycles", stall_cycles, 16'h0000);
      chk("rst_mid_timeout", {15'h0, mem_timeout}, 16'h0000);
      model_reset();
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc();
      chk("post_rst_run", {15'h0, dmem_req}, 16'h0000);

      set_lu(4'd3);
      repeat (70000) cyc();
      chk("stall_saturate", stall_cycles, 16'hFFFF);
      idle();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
